// File: rtl/ex_hilo_muldiv_pkg.sv
// Shared definitions for the execute-stage HI/LO multiply/divide unit:
// operand width, Op encodings and FSM state encodings.
package ex_hilo_muldiv_pkg;

    localparam int HL_XLEN = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_FIX  = 2'b10
    } hl_state_e;

endpackage

// File: rtl/ex_hilo_muldiv_hilo_iter_core.sv
// Unsigned iterative datapath: shift-add multiply and restoring divide on
// operand magnitudes, one bit per step, plus the iteration counter.
module hilo_iter_core
    import ex_hilo_muldiv_pkg::*;
#(
    parameter int XLEN = HL_XLEN,
    parameter int ITER = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   mag_a,
    input  logic [XLEN-1:0]   mag_b,
    output logic              last,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder
);

    localparam int CNT_W = $clog2(ITER + 1);

    logic [CNT_W-1:0]  count;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   quot_r;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN:0]     psum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;

    // Multiplier sits in the low half of prod and is consumed LSB first.
    always_comb begin
        psum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
        rem_sh = {rem_r, quot_r[XLEN-1]};
        diff   = rem_sh - {1'b0, divisor};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (step) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            prod    <= {{XLEN{1'b0}}, mag_b};
            mcand   <= mag_a;
            divisor <= mag_b;
            quot_r  <= mag_a;
            rem_r   <= '0;
        end else if (step) begin
            if (is_div) begin
                // No borrow means the divisor fits: keep the difference, quotient bit 1.
                if (!diff[XLEN]) begin
                    rem_r  <= diff[XLEN-1:0];
                    quot_r <= {quot_r[XLEN-2:0], 1'b1};
                end else begin
                    rem_r  <= rem_sh[XLEN-1:0];
                    quot_r <= {quot_r[XLEN-2:0], 1'b0};
                end
            end else begin
                prod <= {psum, prod[XLEN-1:1]};
            end
        end
    end

    assign last      = (count == CNT_W'(ITER - 1));
    assign product   = prod;
    assign quotient  = quot_r;
    assign remainder = rem_r;

endmodule

// File: rtl/ex_hilo_muldiv.sv
// Execute-stage HI/LO unit: FSM, operand sign handling and the architectural
// HI/LO registers around the iterative multiply/divide core.
module ex_hilo_muldiv
    import ex_hilo_muldiv_pkg::*;
#(
    parameter int XLEN = HL_XLEN,
    parameter int ITER = XLEN  // must equal XLEN
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Start,
    input  logic [2:0]      Op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            Flush,
    input  logic            ReadHL,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO,
    output logic            Busy,
    output logic            Stall,
    output logic            Done
);

    hl_state_e         state, next_state;
    logic              is_mt, signed_op, accept_mt, load, step, write, last;
    logic [2:0]        op_q;
    logic              neg_q, rem_neg_q, b_zero_q;
    logic [XLEN-1:0]   a_q;
    logic [2*XLEN-1:0] product, prod_s, res;
    logic [XLEN-1:0]   quotient, remainder;

    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] x, input logic s);
        return (s && x[XLEN-1]) ? -x : x;
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic s);
        return s ? -x : x;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_w(input logic [2*XLEN-1:0] x, input logic s);
        return s ? -x : x;
    endfunction

    assign is_mt     = (Op == OP_MTHI) || (Op == OP_MTLO);
    assign signed_op = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (Start && !Flush && !is_mt) next_state = S_ITER;
            S_ITER:  if (Flush) next_state = S_IDLE;
                     else if (last) next_state = S_FIX;
            S_FIX:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        Busy      = (state != S_IDLE);
        Stall     = Busy && (ReadHL || Start);
        accept_mt = (state == S_IDLE) && Start && !Flush && is_mt;
        load      = (state == S_IDLE) && Start && !Flush && !is_mt;
        step      = (state == S_ITER);
        write     = (state == S_FIX) && !Flush;
    end

    // Signs are resolved up front; the core only ever sees magnitudes.
    always_ff @(posedge Clk) begin
        if (load) begin
            op_q      <= Op;
            neg_q     <= signed_op && (A[XLEN-1] ^ B[XLEN-1]);
            rem_neg_q <= signed_op && A[XLEN-1];
            b_zero_q  <= (B == '0);
            a_q       <= A;
        end
    end

    hilo_iter_core #(.XLEN(XLEN), .ITER(ITER)) u_core (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .load      (load),
        .step      (step),
        .is_div    (op_q == OP_DIV || op_q == OP_DIVU),
        .mag_a     (abs_if(A, signed_op)),
        .mag_b     (abs_if(B, signed_op)),
        .last      (last),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        prod_s = neg_if_w(product, neg_q);
        case (op_q)
            OP_DIV, OP_DIVU: res = b_zero_q ? {a_q, {XLEN{1'b1}}}
                                            : {neg_if(remainder, rem_neg_q), neg_if(quotient, neg_q)};
            OP_MADD:         res = {HI, LO} + prod_s;
            OP_MSUB:         res = {HI, LO} - prod_s;
            default:         res = prod_s;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            HI   <= '0;
            LO   <= '0;
            Done <= 1'b0;
        end else begin
            Done <= accept_mt || write;
            if (accept_mt && Op == OP_MTHI) HI <= A;
            if (accept_mt && Op == OP_MTLO) LO <= A;
            if (write) {HI, LO} <= res;
        end
    end

endmodule

// File: doc/ex_hilo_muldiv.md
Name: ex_hilo_muldiv

Overview:
- Execute-stage consumer of the ID/EX register's HI/LO control fields (HLOp, HLSel, LOen, HIen) and its operand outputs (Data1O, Data2O).
- Performs iterative multiply and restoring divide, and owns the architectural HI and LO registers.
- Raises Busy and Stall to the hazard unit so the IF/ID and ID/EX registers hold while an operation is in flight.
- The decoder maps HLOp, HLSel, LOen and HIen onto the 3-bit Op field below.

Parameters:
XLEN, 32, operand and HI/LO width.
ITER, XLEN, iteration count per multiply/divide. Must equal XLEN.

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
Start  input  1  request from ID/EX, valid for one cycle
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
A  input  XLEN  rs operand / dividend / multiplicand
B  input  XLEN  rt operand / divisor / multiplier
Flush  input  1  abort the in-flight operation (branch/jump squash)
ReadHL  input  1  mfhi/mflo is in EX this cycle
HI  output  XLEN  architectural HI
LO  output  XLEN  architectural LO
Busy  output  1  state != IDLE
Stall  output  1  Busy & (ReadHL | Start)
Done  output  1  one-cycle pulse after HI/LO update

Behaviour:
- Reset: Rst_n low asynchronously forces HI=0, LO=0, Busy=0, Done=0, state IDLE and counter 0. Reset mid-operation discards the operation.
- State machine has three states: IDLE, ITER, FIX.
- IDLE, Start=1, Flush=0, accept edge E0:
  - Op MTHI: HI<=A, Done=1 next cycle, stay IDLE.
  - Op MTLO: LO<=A, Done=1 next cycle, stay IDLE.
  - All other Ops: latch operand magnitudes (absolute value for signed ops, raw for unsigned), latch result signs, count<=0, go to ITER.
- ITER:
  - Multiply: shift-add, one multiplier bit per edge, 2*XLEN-bit partial product.
  - Divide: restoring divide, one quotient bit per edge, XLEN+1-bit remainder subtract.
  - After the ITER-th edge (E32), go to FIX.
- FIX, edge E33:
  - Apply sign correction.
  - Quotient is negative iff A[31]^B[31]; remainder takes the sign of A.
  - Write results: {HI,LO}<=product; or LO<=quotient, HI<=remainder; or for MADD/MSUB, {HI,LO}<={HI,LO}±signed product, 64-bit wrap.
  - Go to IDLE. Done=1 for the following cycle.
- Latency: HI/LO become visible 33 edges after the accept edge. Busy is high in the cycles after E0 through the cycle before E33.
- Divide by zero (B=0, DIV or DIVU): LO=all ones, HI=A. Still takes full latency, no exception.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, falls out of the magnitude datapath.
- Start while Busy: ignored. The hazard unit is required to hold ID/EX via Stall, so the request is re-presented after Done.
- Flush: in ITER/FIX → return to IDLE next edge, HI/LO unchanged, no Done. In IDLE, Flush with Start → Start ignored. Flush has priority over the FIX write on the same edge.
- Stall is combinational. ReadHL in the Done cycle does not stall, because HI/LO already hold the new values.
- Done is registered and never asserted for two consecutive cycles from a single op.

Decomposition:
- Shared pipeline package holds:
  - the Op encodings as localparams;
  - state encodings IDLE=2'b00, ITER=2'b01, FIX=2'b10;
  - the XLEN constant.
- One natural sub-module, hilo_iter_core: the shift/add/subtract datapath and counter. The top level keeps the FSM, sign handling and the HI/LO registers.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 → after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done high exactly one cycle; Busy high 33 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 → LO=0xFFFFFFFF, HI=7.
- MTHI A=0x12345678, then MADD A=2, B=3 with LO=5 → HI=0x12345678, LO=0x0000000B. Then MSUB A=1, B=0xC → LO=0xFFFFFFFF, HI=0x12345677.
- MULTU started, ReadHL asserted at cycle 10 → Stall=1 until the cycle after E33. A second Start at cycle 5 is ignored, and HI/LO reflect only the first op.
- Flush at cycle 20 of a DIV → Busy drops the next cycle, HI/LO keep prior values, no Done. Flush coincident with FIX → no write.
- Rst_n pulsed low mid-MULT (asynchronous, between edges) → HI=LO=0, Busy=0 immediately. A new MULT after release completes correctly.
